// File: rtl/audio_pkg.sv
// Shared constants, state type and slot-bit helper for the 96 kHz I2S output path.
// Frame timing is fixed: 8 mclk per bclk, 32 bclk per slot, 512 mclk per stereo frame.
package audio_pkg;

    localparam int CLK_PER_BCLK  = 8;
    localparam int BITS_PER_SLOT = 32;
    localparam int FRAME_CLKS    = 512;
    localparam int SMP_W         = 24;

    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int BCLK_SH    = $clog2(CLK_PER_BCLK);
    localparam int SLOT_IDX_W = $clog2(BITS_PER_SLOT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

    // Index 0 is the I2S one-bit delay; 1..SMP_W carry the word MSB first; the rest pad with 0.
    function automatic logic slot_bit(input logic [SMP_W-1:0]      word,
                                      input logic [SLOT_IDX_W-1:0] idx);
        logic [SLOT_IDX_W-1:0] pos;
        pos = SLOT_IDX_W'(SMP_W) - idx;
        if (idx >= SLOT_IDX_W'(1) && idx <= SLOT_IDX_W'(SMP_W))
            return word[pos];
        return 1'b0;
    endfunction

endpackage

// File: rtl/audio_round_sat.sv
// Combinational round-half-up and positive saturation from a wide interpolator sample
// down to the DAC word width; one instance per channel.
module audio_round_sat #(
    parameter int DIN_W    = 34,
    parameter int DOUT_W   = 24,
    parameter int LSB_DROP = 10
) (
    input  logic [DIN_W-1:0]  din,
    output logic [DOUT_W-1:0] dout
);

    logic [DOUT_W-1:0] kept;
    logic [DOUT_W-1:0] sum;
    logic              rnd;
    logic              unused_lsbs;

    assign kept        = din[LSB_DROP+DOUT_W-1:LSB_DROP];
    assign rnd         = din[LSB_DROP-1];
    assign sum         = kept + DOUT_W'(rnd);
    assign unused_lsbs = ^din[LSB_DROP-2:0];

    // Only a positive word can wrap on +1; a negative one moves toward zero.
    always_comb begin
        dout = sum;
        if (!kept[DOUT_W-1] && sum[DOUT_W-1])
            dout = {1'b0, {(DOUT_W-1){1'b1}}};
    end

endmodule

// File: rtl/i2s_tx_96k.sv
// I2S (Philips) transmitter for the 96 kHz path: rounds each stereo pair to 24 bits,
// holds one pair, and serialises it with bclk = clk/8 and lrck = clk/512.
//
// state | meaning
// IDLE  | lines held low, holding register invalidated, counter parked at 0
// PRIME | enabled, counter parked at 0, waiting for the first pair
// RUN   | frame counter running, sample_req issued at each frame start
// DRAIN | run dropped: finish the current frame, then return to IDLE
module i2s_tx_96k #(
    parameter int DIN_W         = 34,
    parameter int DOUT_W        = 24,
    parameter int LSB_DROP      = 10,
    parameter bit UNDERRUN_MUTE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] l_din,
    input  logic [DIN_W-1:0] r_din,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             i2s_sdata,
    output logic             sample_req,
    output logic             underrun,
    output logic             overrun,
    input  logic [1:0]       test_d_select,
    output logic [15:0]      test_data
);

    import audio_pkg::*;

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               active;
    logic               cnt_last;
    logic               frame_load;
    logic               accept;
    logic               underrun_nxt;
    logic               overrun_nxt;
    logic               sreq_nxt;

    logic [DOUT_W-1:0]  l_rs;
    logic [DOUT_W-1:0]  r_rs;
    logic [DOUT_W-1:0]  hold_l;
    logic [DOUT_W-1:0]  hold_r;
    logic               hold_valid;
    logic [DOUT_W-1:0]  tx_l;
    logic [DOUT_W-1:0]  tx_r;
    logic [DOUT_W-1:0]  tx_word;
    logic [7:0]         under_cnt;
    logic [7:0]         over_cnt;

    audio_round_sat #(
        .DIN_W    (DIN_W),
        .DOUT_W   (DOUT_W),
        .LSB_DROP (LSB_DROP)
    ) u_rs_l (
        .din  (l_din),
        .dout (l_rs)
    );

    audio_round_sat #(
        .DIN_W    (DIN_W),
        .DOUT_W   (DOUT_W),
        .LSB_DROP (LSB_DROP)
    ) u_rs_r (
        .din  (r_din),
        .dout (r_rs)
    );

    assign active       = (state == RUN) || (state == DRAIN);
    assign cnt_last     = (cnt == CNT_W'(FRAME_CLKS - 1));
    assign frame_load   = active && (cnt == '0);
    assign accept       = din_valid && (state != IDLE);
    assign underrun_nxt = frame_load && !hold_valid;
    assign overrun_nxt  = accept && hold_valid && !frame_load;
    assign sreq_nxt     = (state == RUN) && (cnt == '0);
    assign tx_word      = cnt[CNT_W-1] ? tx_r : tx_l;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Dropping run on the last clock of a frame skips DRAIN: the frame is already complete.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = PRIME;
            PRIME:   begin
                         if (!run)
                             state_nxt = IDLE;
                         else if (din_valid)
                             state_nxt = RUN;
                     end
            RUN:     if (!run) state_nxt = cnt_last ? IDLE : DRAIN;
            DRAIN:   begin
                         if (run)
                             state_nxt = RUN;
                         else if (cnt_last)
                             state_nxt = IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (active)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // A write landing on the load clock refills the holding register after tx takes the old pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_l     <= '0;
            hold_r     <= '0;
            hold_valid <= 1'b0;
        end else if (state == IDLE) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_l     <= l_rs;
            hold_r     <= r_rs;
            hold_valid <= 1'b1;
        end else if (frame_load) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_l <= '0;
            tx_r <= '0;
        end else if (frame_load) begin
            if (hold_valid) begin
                tx_l <= hold_l;
                tx_r <= hold_r;
            end else if (UNDERRUN_MUTE) begin
                tx_l <= '0;
                tx_r <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i2s_bclk   <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_sdata  <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            i2s_bclk   <= active & cnt[BCLK_SH-1];
            i2s_lrck   <= active & cnt[CNT_W-1];
            sample_req <= sreq_nxt;
            underrun   <= underrun_nxt;
            overrun    <= overrun_nxt;
            if (!active)
                i2s_sdata <= 1'b0;
            else if (cnt[BCLK_SH-1:0] == '0)
                i2s_sdata <= slot_bit(tx_word, cnt[CNT_W-2:BCLK_SH]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            under_cnt <= '0;
            over_cnt  <= '0;
        end else begin
            if (underrun_nxt)
                under_cnt <= under_cnt + 8'd1;
            if (overrun_nxt)
                over_cnt <= over_cnt + 8'd1;
        end
    end

    always_comb begin
        test_data = '0;
        case (test_d_select)
            2'd0:    test_data = hold_l[DOUT_W-1:DOUT_W-16];
            2'd1:    test_data = hold_r[DOUT_W-1:DOUT_W-16];
            2'd2:    test_data = {state, cnt, 5'b0};
            default: test_data = {under_cnt, over_cnt};
        endcase
    end

endmodule
